// File: rtl/latch_sched_pkg.sv
// rtl/latch_sched_pkg.sv - shared state encoding and window constants for the latch write scheduler
package latch_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int SETUP_CYC = 1;
    localparam int HOLD_CYC  = 1;
    // Wide enough for PULSE up to 4 and for the setup/hold windows.
    localparam int CNT_W     = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // ptr names the requester that wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// rtl/latch_wr_sched.sv - arbitrated setup/open/hold write sequencer for a bank of transparent-low latches
import latch_sched_pkg::*;

module latch_wr_sched #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 4,
    parameter int PULSE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       REQ,
    input  logic [AW-1:0]    ADDR0,
    input  logic [AW-1:0]    ADDR1,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    output logic [1:0]       ACK,
    output logic             ERR,
    output logic             BUSY,
    output logic [DEPTH-1:0] LE_N,
    output logic [WIDTH-1:0] WD
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               ptr;
    logic [1:0]         gnt;
    logic               grant_q;
    logic [AW-1:0]      addr_q;
    logic               bad_q;
    logic [AW-1:0]      addr_mux;
    logic [DEPTH-1:0]   le_open;
    logic [DEPTH-1:0]   le_n_d;
    logic [1:0]         ack_d;
    logic               err_d;

    rr_arb2 u_arb (
        .req (REQ),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign addr_mux = gnt[1] ? ADDR1 : ADDR0;
    assign le_open  = bad_q ? {DEPTH{1'b1}} : ~(DEPTH'(1) << addr_q);
    assign BUSY     = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // LE_N/ACK/ERR are computed one cycle early so they leave flops directly.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        le_n_d  = {DEPTH{1'b1}};
        ack_d   = 2'b00;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|REQ) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = OPEN;
                    cnt_d   = '0;
                    le_n_d  = le_open;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            OPEN: begin
                if (cnt == CNT_W'(PULSE - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt + 1'b1;
                    le_n_d = le_open;
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ack_d   = grant_q ? 2'b10 : 2'b01;
                    err_d   = bad_q;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LE_N    <= {DEPTH{1'b1}};
            ACK     <= 2'b00;
            ERR     <= 1'b0;
            WD      <= '0;
            ptr     <= 1'b0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            LE_N <= le_n_d;
            ACK  <= ack_d;
            ERR  <= err_d;
            if (state == IDLE && (|REQ)) begin
                grant_q <= gnt[1];
                addr_q  <= addr_mux;
                bad_q   <= !({1'b0, addr_mux} < (AW + 1)'(DEPTH));
                WD      <= gnt[1] ? DATA1 : DATA0;
            end
            if (state == DONE)
                ptr <= ~grant_q;
        end
    end

endmodule

// File: tb/tb_latch_wr_sched.sv
// tb/tb_latch_wr_sched.sv - directed vector bench for latch_wr_sched (DEPTH=6, PULSE=4)
module tb_latch_wr_sched;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AW    = 4;
    localparam int PULSE = 4;

    logic             CLK;
    logic             RST;
    logic [1:0]       REQ;
    logic [AW-1:0]    ADDR0, ADDR1;
    logic [WIDTH-1:0] DATA0, DATA1;
    logic [1:0]       ACK;
    logic             ERR, BUSY;
    logic [DEPTH-1:0] LE_N;
    logic [WIDTH-1:0] WD;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             rst;
        logic [1:0]       req;
        logic [AW-1:0]    a0, a1;
        logic [WIDTH-1:0] d0, d1;
        logic [1:0]       ack;
        logic [DEPTH-1:0] le_n;
        logic [WIDTH-1:0] wd;
        logic             busy, err;
    } vec_t;

    vec_t vq[$];

    latch_wr_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .PULSE(PULSE)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .ADDR0 (ADDR0),
        .ADDR1 (ADDR1),
        .DATA0 (DATA0),
        .DATA1 (DATA1),
        .ACK   (ACK),
        .ERR   (ERR),
        .BUSY  (BUSY),
        .LE_N  (LE_N),
        .WD    (WD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // At most one latch open in any cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            total++;
            if (!(LE_N == {DEPTH{1'b1}} || $onehot(~LE_N))) begin
                bad++;
                $display("FAIL le_n_onehot got=%0h exp=all-ones-or-one-low", LE_N);
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, got, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [1:0] req,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                input logic [1:0] ack, input logic [DEPTH-1:0] le_n,
                                input logic [WIDTH-1:0] wd, input logic busy, input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.ack = ack; v.le_n = le_n; v.wd = wd; v.busy = busy; v.err = err;
        vq.push_back(v);
    endfunction

    task automatic reset_dut();
        RST = 1'b1;
        REQ = 2'b00;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1; REQ = 2'b00; ADDR0 = '0; ADDR1 = '0; DATA0 = '0; DATA1 = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_le_n", 0, 32'(LE_N), 32'h3F);
        chk("reset_busy", 0, 32'(BUSY), 32'h0);

        // Single write to word 3.
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 6'h3F, 8'h00, 0, 0);
        add(0, 1, 3, 0, 8'hA5, 8'h00, 0, 6'h3F, 8'hA5, 1, 0);
        for (int i = 0; i < PULSE; i++) add(0, 1, 3, 0, 8'hA5, 8'h00, 0, 6'h37, 8'hA5, 1, 0);
        add(0, 1, 3, 0, 8'hA5, 8'h00, 0, 6'h3F, 8'hA5, 1, 0);
        add(0, 1, 3, 0, 8'hA5, 8'h00, 1, 6'h3F, 8'hA5, 1, 0);
        add(0, 0, 3, 0, 8'hA5, 8'h00, 0, 6'h3F, 8'hA5, 0, 0);

        // Both requesting: 0 first, then 1, then 0 again.
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 6'h3F, 8'h00, 0, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h11, 1, 0);
        for (int i = 0; i < PULSE; i++) add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3D, 8'h11, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h11, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 1, 6'h3F, 8'h11, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h11, 0, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h22, 1, 0);
        for (int i = 0; i < PULSE; i++) add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3B, 8'h22, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h22, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 2, 6'h3F, 8'h22, 1, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h22, 0, 0);
        add(0, 3, 1, 2, 8'h11, 8'h22, 0, 6'h3F, 8'h11, 1, 0);

        // Out-of-range address from requester 1.
        add(1, 0, 0, 7, 8'h00, 8'h5A, 0, 6'h3F, 8'h00, 0, 0);
        add(0, 2, 0, 7, 8'h00, 8'h5A, 0, 6'h3F, 8'h5A, 1, 0);
        for (int i = 0; i < PULSE + 1; i++) add(0, 2, 0, 7, 8'h00, 8'h5A, 0, 6'h3F, 8'h5A, 1, 0);
        add(0, 2, 0, 7, 8'h00, 8'h5A, 2, 6'h3F, 8'h5A, 1, 1);
        add(0, 0, 0, 7, 8'h00, 8'h5A, 0, 6'h3F, 8'h5A, 0, 0);

        // DATA0/ADDR0 churn after capture.
        add(0, 1, 0, 0, 8'h3C, 8'h00, 0, 6'h3F, 8'h3C, 1, 0);
        add(0, 1, 5, 0, 8'hC3, 8'h00, 0, 6'h3E, 8'h3C, 1, 0);
        add(0, 1, 4, 0, 8'h3C, 8'h00, 0, 6'h3E, 8'h3C, 1, 0);
        add(0, 1, 5, 0, 8'hC3, 8'h00, 0, 6'h3E, 8'h3C, 1, 0);
        add(0, 1, 4, 0, 8'h3C, 8'h00, 0, 6'h3E, 8'h3C, 1, 0);
        add(0, 1, 5, 0, 8'hC3, 8'h00, 0, 6'h3F, 8'h3C, 1, 0);
        add(0, 1, 4, 0, 8'h3C, 8'h00, 1, 6'h3F, 8'h3C, 1, 0);
        add(0, 0, 4, 0, 8'hC3, 8'h00, 0, 6'h3F, 8'h3C, 0, 0);

        foreach (vq[i]) begin
            RST = vq[i].rst; REQ = vq[i].req;
            ADDR0 = vq[i].a0; ADDR1 = vq[i].a1;
            DATA0 = vq[i].d0; DATA1 = vq[i].d1;
            @(posedge CLK);
            #1;
            chk("ack",  i, 32'(ACK),  32'(vq[i].ack));
            chk("le_n", i, 32'(LE_N), 32'(vq[i].le_n));
            chk("wd",   i, 32'(WD),   32'(vq[i].wd));
            chk("busy", i, 32'(BUSY), 32'(vq[i].busy));
            chk("err",  i, 32'(ERR),  32'(vq[i].err));
        end
        RST = 1'b0;

        // Reset mid-OPEN at word 5, then a clean retry.
        reset_dut();
        REQ = 2'b01; ADDR0 = 4'd5; DATA0 = 8'h77;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_open_le_n", 0, 32'(LE_N), 32'h1F);
        RST = 1'b1;
        #1;
        chk("rst_async_le_n", 0, 32'(LE_N), 32'h3F);
        chk("rst_async_busy", 0, 32'(BUSY), 32'h0);
        chk("rst_async_ack",  0, 32'(ACK),  32'h0);
        @(posedge CLK); #1;
        chk("rst_hold_ack", 0, 32'(ACK), 32'h0);
        RST = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            n = c;
            if (ACK != 2'b00) break;
        end
        chk("retry_latency", 0, 32'(n), 32'(PULSE + 3));
        chk("retry_ack",     0, 32'(ACK), 32'h1);
        chk("retry_wd",      0, 32'(WD), 32'h77);
        REQ = 2'b00;
        @(posedge CLK); #1;

        // Requester 0 drops REQ during OPEN; the write still completes.
        reset_dut();
        REQ = 2'b01; ADDR0 = 4'd2; DATA0 = 8'h99;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            n = c;
            if (c == 2) REQ = 2'b00;
            if (ACK != 2'b00) break;
        end
        chk("drop_latency", 0, 32'(n), 32'd7);
        chk("drop_ack",     0, 32'(ACK), 32'h1);
        @(posedge CLK); #1;
        chk("drop_idle_busy", 0, 32'(BUSY), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
